// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC processing element slice.
package mac_pkg;

  localparam int DefWidthA = 8;
  localparam int DefWidthB = 8;
  localparam int DefKWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/mac_pe_seq.sv
// Operand join, dot-product sequencing and result drain for one mac_pe.
// The PE itself lives beside this block in the tile wrapper.
module mac_pe_seq
  import mac_pkg::*;
#(
  parameter int DataWidthA = DefWidthA,
  parameter int DataWidthB = DefWidthB,
  parameter int DataWidthC = DataWidthA + DataWidthB,
  parameter int KWidth     = DefKWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [KWidth-1:0]     k_len_i,
  output logic                  busy_o,
  input  logic [DataWidthA-1:0] a_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DataWidthB-1:0] b_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic [DataWidthA-1:0] pe_a_o,
  output logic [DataWidthB-1:0] pe_b_o,
  output logic                  pe_a_valid_o,
  output logic                  pe_b_valid_o,
  output logic                  pe_acc_clr_o,
  input  logic [DataWidthC-1:0] pe_c_i,
  output logic [DataWidthC-1:0] res_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);

  localparam logic [KWidth-1:0] KOne = KWidth'(1);

  state_e                state_q, state_d;
  logic [KWidth-1:0]     cnt_q, cnt_d;
  logic [KWidth-1:0]     k_q, k_d;
  logic [DataWidthC-1:0] res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic                  fire;

  assign fire = a_valid_i && b_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    a_ready_o    = 1'b0;
    b_ready_o    = 1'b0;
    pe_a_o       = '0;
    pe_b_o       = '0;
    pe_a_valid_o = 1'b0;
    pe_b_valid_o = 1'b0;
    pe_acc_clr_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          k_d   = k_len_i;
          cnt_d = '0;
          if (k_len_i == '0) begin
            // empty job: PE loads zero so WAIT captures a clean 0
            pe_acc_clr_o = 1'b1;
            state_d      = WAIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_ready_o = b_valid_i;
        b_ready_o = a_valid_i;
        if (fire) begin
          pe_a_o       = a_i;
          pe_b_o       = b_i;
          pe_a_valid_o = 1'b1;
          pe_b_valid_o = 1'b1;
          pe_acc_clr_o = (cnt_q == '0);
          cnt_d        = cnt_q + KOne;
          if (cnt_q == k_q - KOne) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        res_d       = pe_c_i;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;

endmodule
